// File: rtl/img_pkg.sv
// Shared constants, FSM encoding and helpers for the image line-buffer block.
package img_pkg;

    localparam int NUM_LB     = 4;
    localparam int LINE_W_DEF = 512;
    localparam int PIX_W      = 8;
    localparam int WIN_W      = 72;
    localparam int ROW_W      = 3 * PIX_W;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } rd_state_e;

    function automatic logic [1:0] lb_add(
        input logic [1:0] sel,
        input logic [1:0] off
    );
        return sel + off;
    endfunction

endpackage

// File: rtl/line_buffer.sv
// One image line of storage: single write port, 3-pixel registered read port.
module line_buffer
    import img_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF,
    localparam int AW = $clog2(LINE_W)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_col,
    input  logic [PIX_W-1:0] i_wr_data,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_col,
    output logic [ROW_W-1:0] o_rd_data
);

    logic [PIX_W-1:0] mem [LINE_W];
    logic [PIX_W-1:0] tap [3];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_col] <= i_wr_data;
        end
    end

    // Taps past the right edge of the line read as black.
    for (genvar j = 0; j < 3; j++) begin : g_tap
        logic [AW:0] col;
        assign col    = {1'b0, i_rd_col} + (AW+1)'(j);
        assign tap[j] = (col < (AW+1)'(LINE_W)) ? mem[col[AW-1:0]] : '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_rd_data <= '0;
        end else if (i_rd_en) begin
            o_rd_data <= {tap[2], tap[1], tap[0]};
        end
    end

endmodule

// File: rtl/image_control.sv
// Four-line ring buffer feeding 3x3 windows to the Sobel stage.
// Optional sticky overflow flag: define IMAGE_CONTROL_OVF_EN.
module image_control
    import img_pkg::*;
#(
    parameter int LINE_W = LINE_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [PIX_W-1:0] i_pixel_data,
    input  logic             i_pixel_data_valid,
    output logic             o_ready,
    input  logic             i_rd_en,
    output logic [WIN_W-1:0] o_pixel_data,
    output logic             o_pixel_data_valid,
    output logic             o_intr
`ifdef IMAGE_CONTROL_OVF_EN
    ,
    output logic             o_overflow
`endif
);

    localparam int AW = $clog2(LINE_W);

    logic [1:0]      wr_sel;
    logic [1:0]      rd_sel;
    logic [1:0]      win_sel;
    logic [AW-1:0]   wr_col;
    logic [AW-1:0]   rd_col;
    logic [2:0]      occ;
    rd_state_e       state;

    logic            wr_fire;
    logic            wr_wrap;
    logic            rd_fire;
    logic            rd_last;
    logic [ROW_W-1:0] lb_q [NUM_LB];

    assign o_ready = (occ < 3'd4);
    assign wr_fire = i_pixel_data_valid && o_ready;
    assign wr_wrap = wr_fire && (wr_col == AW'(LINE_W - 1));
    assign rd_fire = (state == ST_RD) && i_rd_en;
    assign rd_last = rd_fire && (rd_col == AW'(LINE_W - 1));

    // Only the three rows of the current window are loaded on a read.
    for (genvar i = 0; i < NUM_LB; i++) begin : g_lb
        logic [1:0] row_off;
        assign row_off = 2'(i) - rd_sel;

        line_buffer #(
            .LINE_W (LINE_W)
        ) u_lb (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_wr_en   (wr_fire && (wr_sel == 2'(i))),
            .i_wr_col  (wr_col),
            .i_wr_data (i_pixel_data),
            .i_rd_en   (rd_fire && (row_off != 2'd3)),
            .i_rd_col  (rd_col),
            .o_rd_data (lb_q[i])
        );
    end

    assign o_pixel_data = {
        lb_q[lb_add(win_sel, 2'd2)],
        lb_q[lb_add(win_sel, 2'd1)],
        lb_q[win_sel]
    };

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_sel <= '0;
            wr_col <= '0;
            occ    <= '0;
        end else begin
            if (wr_fire) begin
                wr_col <= wr_col + AW'(1);
                if (wr_wrap) begin
                    wr_sel <= wr_sel + 2'd1;
                end
            end
            case ({wr_wrap, rd_last})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state              <= ST_IDLE;
            rd_sel             <= '0;
            rd_col             <= '0;
            win_sel            <= '0;
            o_pixel_data_valid <= 1'b0;
            o_intr             <= 1'b0;
        end else begin
            o_pixel_data_valid <= rd_fire;
            o_intr             <= rd_last;
            if (rd_fire) begin
                win_sel <= rd_sel;
            end
            unique case (state)
                ST_IDLE: begin
                    if (occ >= 3'd3) begin
                        state <= ST_RD;
                    end
                end
                ST_RD: begin
                    if (rd_fire) begin
                        rd_col <= rd_col + AW'(1);
                        if (rd_last) begin
                            rd_sel <= rd_sel + 2'd1;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef IMAGE_CONTROL_OVF_EN
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_overflow <= 1'b0;
        end else if (i_pixel_data_valid && !o_ready) begin
            o_overflow <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_image_control.sv
// Directed self-checking bench for image_control with LINE_W = 8.
module tb_image_control;

    logic        i_clk;
    logic        i_rst;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic        o_ready;
    logic        i_rd_en;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;
`ifdef IMAGE_CONTROL_OVF_EN
    logic        o_overflow;
`endif

    int checks = 0;
    int errors = 0;
    int intrs  = 0;
    int intr_win = 0;
    logic [71:0] wins [$];

    image_control #(
        .LINE_W (8)
    ) dut (
        .i_clk              (i_clk),
        .i_rst              (i_rst),
        .i_pixel_data       (i_pixel_data),
        .i_pixel_data_valid (i_pixel_data_valid),
        .o_ready            (o_ready),
        .i_rd_en            (i_rd_en),
        .o_pixel_data       (o_pixel_data),
        .o_pixel_data_valid (o_pixel_data_valid),
        .o_intr             (o_intr)
`ifdef IMAGE_CONTROL_OVF_EN
        ,
        .o_overflow         (o_overflow)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [71:0] obs,
                       input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int idx);
        return 8'((idx / 8) * 16 + (idx % 8));
    endfunction

    function automatic logic [71:0] exp_win(input int l, input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                if (c + j < 8) begin
                    w[(r*3+j)*8 +: 8] = 8'((l + r) * 16 + c + j);
                end
            end
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
        if (o_pixel_data_valid) begin
            wins.push_back(o_pixel_data);
        end
        if (o_intr) begin
            intrs++;
            intr_win = wins.size();
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic write_pix(input int n, input int start);
        for (int i = 0; i < n; i++) begin
            i_pixel_data       = pix(start + i);
            i_pixel_data_valid = 1'b1;
            tick();
        end
        i_pixel_data_valid = 1'b0;
    endtask

    task automatic check_line(input string tag, input int base, input int l);
        logic [71:0] g;
        for (int c = 0; c < 8; c++) begin
            g = (base + c < wins.size()) ? wins[base + c] : 'x;
            chk($sformatf("%s col%0d", tag, c), g, exp_win(l, c));
        end
    endtask

    task automatic do_reset(input string tag);
        i_rst = 1'b1;
        #2;
        chk({tag, " rst ready"}, 72'(o_ready), 72'd1);
        chk({tag, " rst valid"}, 72'(o_pixel_data_valid), 72'd0);
        chk({tag, " rst intr"}, 72'(o_intr), 72'd0);
        chk({tag, " rst data"}, o_pixel_data, 72'd0);
        tick();
        i_rst = 1'b0;
        wins.delete();
        intrs    = 0;
        intr_win = 0;
    endtask

    initial begin
        i_rst              = 1'b1;
        i_pixel_data       = '0;
        i_pixel_data_valid = 1'b0;
        i_rd_en            = 1'b0;
        #1;

        // Basic three-line fill then one full line of windows.
        do_reset("t1");
        i_rd_en = 1'b1;
        write_pix(24, 0);
        chk("t1 none before RD", 72'(wins.size()), 72'd0);
        tick();
        chk("t1 idle->rd no valid", 72'(o_pixel_data_valid), 72'd0);
        tick();
        chk("t1 first valid", 72'(o_pixel_data_valid), 72'd1);
        chk("t1 first window", o_pixel_data, 72'h222120121110020100);
        ticks(12);
        chk("t1 count", 72'(wins.size()), 72'd8);
        check_line("t1", 0, 0);
        chk("t1 right edge", wins[7], 72'h000027000017000007);
        chk("t1 intr pulses", 72'(intrs), 72'd1);
        chk("t1 intr after win8", 72'(intr_win), 72'd8);
        chk("t1 ready", 72'(o_ready), 72'd1);

        // Line write wrap coincides with line read completion.
        do_reset("t2");
        i_rd_en = 1'b1;
        write_pix(24, 0);
        tick();
        write_pix(8, 24);
        chk("t2 ready same cycle", 72'(o_ready), 72'd1);
        ticks(12);
        chk("t2 count", 72'(wins.size()), 72'd16);
        check_line("t2 l0", 0, 0);
        check_line("t2 l1", 8, 1);
        chk("t2 intr pulses", 72'(intrs), 72'd2);

        // Fill all four buffers with reads stalled; extra writes dropped.
        do_reset("t3");
        i_rd_en = 1'b0;
        write_pix(31, 0);
        chk("t3 ready at 31", 72'(o_ready), 72'd1);
`ifdef IMAGE_CONTROL_OVF_EN
        chk("t3 ovf clear", 72'(o_overflow), 72'd0);
`endif
        write_pix(1, 31);
        chk("t3 ready low at 32", 72'(o_ready), 72'd0);
        write_pix(8, 32);
        chk("t3 ready low at 40", 72'(o_ready), 72'd0);
        chk("t3 no windows", 72'(wins.size()), 72'd0);
`ifdef IMAGE_CONTROL_OVF_EN
        chk("t3 ovf set", 72'(o_overflow), 72'd1);
`endif
        i_rd_en = 1'b1;
        ticks(20);
        chk("t3 count", 72'(wins.size()), 72'd16);
        check_line("t3 l0", 0, 0);
        check_line("t3 l1", 8, 1);
        chk("t3 ready after drain", 72'(o_ready), 72'd1);

        // Read enable toggling every cycle halves the window rate.
        do_reset("t4");
        i_rd_en = 1'b0;
        write_pix(24, 0);
        tick();
        for (int i = 0; i < 16; i++) begin
            i_rd_en = (i % 2 == 0);
            tick();
        end
        i_rd_en = 1'b0;
        chk("t4 count", 72'(wins.size()), 72'd8);
        check_line("t4", 0, 0);
        chk("t4 intr pulses", 72'(intrs), 72'd1);

        // Reset in the middle of a line read, then a clean rerun.
        do_reset("t5");
        i_rd_en = 1'b1;
        write_pix(24, 0);
        ticks(5);
        chk("t5 partial count", 72'(wins.size()), 72'd4);
        chk("t5 valid pre-rst", 72'(o_pixel_data_valid), 72'd1);
        i_rst = 1'b1;
        #1;
        chk("t5 async valid", 72'(o_pixel_data_valid), 72'd0);
        chk("t5 async intr", 72'(o_intr), 72'd0);
        chk("t5 async data", o_pixel_data, 72'd0);
        chk("t5 async ready", 72'(o_ready), 72'd1);
        tick();
        i_rst = 1'b0;
        wins.delete();
        intrs    = 0;
        intr_win = 0;
        write_pix(24, 0);
        chk("t5 ready after refill", 72'(o_ready), 72'd1);
        ticks(14);
        chk("t5 count", 72'(wins.size()), 72'd8);
        check_line("t5", 0, 0);
        chk("t5 intr pulses", 72'(intrs), 72'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
